full_adder_16bit_slice: RTL and testbench
=========================================

Name: full_adder_16bit_slice

Overview:
- 16-bit (2-byte) binary adder slice: s = a + b + ci, with carry-out co.
- Built as a carry-lookahead adder over four 4-bit groups.
- Also exports group generate/propagate so wide adders can chain slices by ripple or by a higher-level lookahead.
- Building block of the wide (e.g. 1024-bit) adder in the modular-square datapath.

Parameters:
- REGISTER_OUT, default 1: 1 = s/co/g_out/p_out/out_valid registered (1-cycle latency); 0 = purely combinational outputs.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a/b/ci this cycle.
- a  input  16  addend, unsigned.
- b  input  16  addend, unsigned.
- ci  input  1  carry-in (bit 0).
- s  output  16  sum bits [15:0].
- co  output  1  carry-out of bit 15.
- g_out  output  1  block generate: the slice produces a carry regardless of ci.
- p_out  output  1  block propagate: a^b == 16'hFFFF.
- out_valid  output  1  s/co/g_out/p_out are valid.

Behaviour:
- Arithmetic: {co, s} = a + b + ci, a 17-bit exact result with no saturation.
  - Wrap example: 16'hFFFF + 16'h0001 + 0 gives s=0, co=1.
- Bit level: g_i = a_i & b_i; p_i = a_i ^ b_i; s_i = p_i ^ c_i.
- Group level: each 4-bit group computes group G/P with lookahead equations.
  - Group carries c4, c8, c12, c16 come from a 2nd-level lookahead on group G/P and ci.
  - No ripple longer than 4 bits.
- Block outputs:
  - g_out = block G, independent of ci.
  - p_out = AND of all p_i.
  - co = g_out | (p_out & ci).
- REGISTER_OUT=1:
  - Inputs sampled on the rising clk edge when in_valid=1.
  - Results appear the next cycle with out_valid=1.
  - When in_valid=0: out_valid=0 next cycle and data registers hold their previous values.
  - Back-to-back in_valid gives one result per cycle.
- Reset (REGISTER_OUT=1):
  - While reset=1 at a clk edge, all outputs clear next cycle: s=0, co=0, g_out=0, p_out=0, out_valid=0.
  - Reset takes priority over a simultaneous in_valid; that input is dropped.
  - Reset mid-stream discards any in-flight result.
- REGISTER_OUT=0:
  - Outputs are pure combinational functions of a/b/ci.
  - out_valid = in_valid.
  - clk/reset are unused.
  - This mode is used for ripple chaining inside a wide adder.
- No X propagation from unused paths; every output is driven in every mode.

Decomposition:
- Shared package adder_pkg:
  - constant SLICE_W=16, GROUP_W=4, NUM_GROUPS=4.
  - typedef slice_t (logic [15:0]).
  - typedef gp_t (struct of g, p).
- One natural sub-module: cla_group_4bit.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], group g, group p.
  - Instantiated 4x, with the 2nd-level lookahead in the top.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, a=16'h1234 -> outputs all 0 and out_valid=0 after reset; first post-reset in_valid result appears exactly 1 cycle later.
- Basic add: a=16'h1234, b=16'h4321, ci=0 -> s=16'h5555, co=0, g_out=0, p_out=0; with ci=1 -> s=16'h5556.
- Full propagate: a=16'hFFFF, b=16'h0000, ci=1 -> s=16'h0000, co=1, p_out=1, g_out=0; same with ci=0 -> s=16'hFFFF, co=0.
- Generate/max: a=16'hFFFF, b=16'hFFFF, ci=1 -> s=16'hFFFF, co=1, g_out=1; a=16'h8000, b=16'h8000, ci=0 -> s=0, co=1.
- Group-boundary carries: a=16'h0FFF, b=16'h0001 -> s=16'h1000; a=16'h00FF, b=16'h0001 -> s=16'h0100; a=16'h000F, b=16'h0001 -> s=16'h0010.
- Streaming/random:
  - 10k random {a, b, ci} with random in_valid gaps and one mid-stream reset.
  - Every out_valid result must equal {co, s} = a+b+ci from one cycle earlier.
  - Repeat with REGISTER_OUT=0, checking same-cycle equality.
  - Chain 4 instances with REGISTER_OUT=0 and check a 64-bit sum.

Source files
------------

// File: rtl/full_adder_16bit_slice_pkg.sv
// Purpose: shared widths and types for the 16-bit carry-lookahead adder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a; the slice has no ready signal and accepts a new input every cycle.
package adder_pkg;

  localparam int SLICE_W    = 16;
  localparam int GROUP_W    = 4;
  localparam int NUM_GROUPS = 4;

  typedef logic [SLICE_W-1:0] slice_t;

  // Generate/propagate pair for a bit, a group or a whole slice.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

endpackage

// File: rtl/full_adder_16bit_slice_if.sv
// Purpose: operand/result bundle of one adder slice.
// Latency: n/a (wiring only).
// Backpressure: none; in_valid/out_valid only qualify data, there is no ready.
// Signals: in_valid, a, b, ci  (master -> slave)
//          s, co, g_out, p_out, out_valid  (slave -> master)
interface full_adder_16bit_slice_if;
  import adder_pkg::*;

  logic   in_valid;
  slice_t a;
  slice_t b;
  logic   ci;
  slice_t s;
  logic   co;
  logic   g_out;
  logic   p_out;
  logic   out_valid;

  modport master (
    output in_valid, a, b, ci,
    input  s, co, g_out, p_out, out_valid
  );

  modport slave (
    input  in_valid, a, b, ci,
    output s, co, g_out, p_out, out_valid
  );

endinterface

// File: rtl/full_adder_16bit_slice_cla_group.sv
// Purpose: 4-bit carry-lookahead group: sum bits plus group generate/propagate.
// Latency: combinational.
// Backpressure: none.
// Ports: a[3:0], b[3:0], cin in; s[3:0], gp (group g/p) out.
module cla_group_4bit
  import adder_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] s,
  output gp_t                gp
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is a flat sum of products from cin; nothing ripples.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

  // Group g/p exclude cin so the next level can look ahead across groups.
  assign gp.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
  assign gp.p = &p;

endmodule

// File: rtl/full_adder_16bit_slice.sv
// Purpose: 16-bit two-level carry-lookahead adder slice, {co,s} = a + b + ci, with block g/p export.
// Latency: 1 cycle when REGISTER_OUT=1, combinational when REGISTER_OUT=0.
// Backpressure: none; accepts one operand set per cycle, results are never stalled.
// Ports: clk, reset (sync, active-high; unused when REGISTER_OUT=0), bus (slave side of the slice interface).
module full_adder_16bit_slice #(
  parameter bit REGISTER_OUT = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  full_adder_16bit_slice_if.slave bus
);
  import adder_pkg::*;

  gp_t [NUM_GROUPS-1:0] grp;
  logic [NUM_GROUPS-1:0] gc;   // carry into each 4-bit group
  slice_t                sum_c;
  logic                  blk_g;
  logic                  blk_p;
  logic                  co_c;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
      cla_group_4bit u_grp (
        .a   (bus.a[gi*GROUP_W +: GROUP_W]),
        .b   (bus.b[gi*GROUP_W +: GROUP_W]),
        .cin (gc[gi]),
        .s   (sum_c[gi*GROUP_W +: GROUP_W]),
        .gp  (grp[gi])
      );
    end
  endgenerate

  // Second-level lookahead: group carries straight from group g/p and ci.
  assign gc[0] = bus.ci;
  assign gc[1] = grp[0].g | (grp[0].p & bus.ci);
  assign gc[2] = grp[1].g | (grp[1].p & grp[0].g) | (grp[1].p & grp[0].p & bus.ci);
  assign gc[3] = grp[2].g | (grp[2].p & grp[1].g) | (grp[2].p & grp[1].p & grp[0].g)
               | (grp[2].p & grp[1].p & grp[0].p & bus.ci);

  assign blk_g = grp[3].g | (grp[3].p & grp[2].g) | (grp[3].p & grp[2].p & grp[1].g)
               | (grp[3].p & grp[2].p & grp[1].p & grp[0].g);
  assign blk_p = grp[3].p & grp[2].p & grp[1].p & grp[0].p;
  // c16 in the same lookahead form; this is the slice carry-out.
  assign co_c  = blk_g | (blk_p & bus.ci);

  generate
    if (REGISTER_OUT) begin : g_reg
      slice_t s_q;
      logic   co_q;
      logic   g_q;
      logic   p_q;
      logic   vld_q;

      // Data registers load only on in_valid so the last result is held across gaps.
      always_ff @(posedge clk) begin
        if (reset) begin
          s_q   <= '0;
          co_q  <= 1'b0;
          g_q   <= 1'b0;
          p_q   <= 1'b0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= bus.in_valid;
          if (bus.in_valid) begin
            s_q  <= sum_c;
            co_q <= co_c;
            g_q  <= blk_g;
            p_q  <= blk_p;
          end
        end
      end

      assign bus.s         = s_q;
      assign bus.co        = co_q;
      assign bus.g_out     = g_q;
      assign bus.p_out     = p_q;
      assign bus.out_valid = vld_q;
    end else begin : g_comb
      // Clock and reset have no role in the combinational form.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;

      assign bus.s         = sum_c;
      assign bus.co        = co_c;
      assign bus.g_out     = blk_g;
      assign bus.p_out     = blk_p;
      assign bus.out_valid = bus.in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_16bit_slice.sv
module tb_full_adder_16bit_slice;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  full_adder_16bit_slice_if r_if ();   // registered slice
  full_adder_16bit_slice_if c_if ();   // combinational slice
  full_adder_16bit_slice_if ch0 ();    // 64-bit ripple chain of combinational slices
  full_adder_16bit_slice_if ch1 ();
  full_adder_16bit_slice_if ch2 ();
  full_adder_16bit_slice_if ch3 ();

  full_adder_16bit_slice #(.REGISTER_OUT(1'b1)) u_reg (.clk(clk), .reset(reset), .bus(r_if));
  full_adder_16bit_slice #(.REGISTER_OUT(1'b0)) u_comb (.clk(clk), .reset(reset), .bus(c_if));
  full_adder_16bit_slice #(.REGISTER_OUT(1'b0)) u_ch0 (.clk(clk), .reset(reset), .bus(ch0));
  full_adder_16bit_slice #(.REGISTER_OUT(1'b0)) u_ch1 (.clk(clk), .reset(reset), .bus(ch1));
  full_adder_16bit_slice #(.REGISTER_OUT(1'b0)) u_ch2 (.clk(clk), .reset(reset), .bus(ch2));
  full_adder_16bit_slice #(.REGISTER_OUT(1'b0)) u_ch3 (.clk(clk), .reset(reset), .bus(ch3));

  assign ch1.ci = ch0.co;
  assign ch2.ci = ch1.co;
  assign ch3.ci = ch2.co;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer addition. Block generate is the carry-out with ci forced to 0;
  // block propagate means every bit position differs.
  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {16'd0, ci};
  endfunction

  function automatic logic ref_g(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[16];
  endfunction

  function automatic logic ref_p(input logic [15:0] a, input logic [15:0] b);
    return (a ^ b) == 16'hFFFF;
  endfunction

  // {out_valid, co, s, g_out, p_out}
  function automatic logic [19:0] ref_all(input logic v, input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [16:0] t;
    t = ref_sum(a, b, ci);
    return {v, t[16], t[15:0], ref_g(a, b), ref_p(a, b)};
  endfunction

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic ci);
    r_if.in_valid = v; r_if.a = a; r_if.b = b; r_if.ci = ci;
    c_if.in_valid = v; c_if.a = a; c_if.b = b; c_if.ci = ci;
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    reset = 1'b1;
    drive(1'b1, 16'h1234, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    obs = {r_if.out_valid, r_if.co, r_if.s, r_if.g_out, r_if.p_out};
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_clear: got %h want %h", obs, 20'h0);
    end
    reset = 1'b0;
    drive(1'b1, 16'h1234, 16'h4321, 1'b0);
    @(posedge clk);
    #1;
    obs = {r_if.out_valid, r_if.co, r_if.s, r_if.g_out, r_if.p_out};
    checks++;
    if (obs !== {1'b1, 1'b0, 16'h5555, 2'b00}) begin
      errors++;
      $display("FAIL reset_first_result: got %h want %h", obs, {1'b1, 1'b0, 16'h5555, 2'b00});
    end
    drive(1'b0, 16'hAAAA, 16'h0F0F, 1'b1);
    @(posedge clk);
    #1;
    obs = {r_if.out_valid, r_if.co, r_if.s, r_if.g_out, r_if.p_out};
    checks++;
    if (obs !== {1'b0, 1'b0, 16'h5555, 2'b00}) begin
      errors++;
      $display("FAIL idle_hold: got %h want %h", obs, {1'b0, 1'b0, 16'h5555, 2'b00});
    end
  endtask

  localparam int NV = 10;
  localparam logic [15:0] TA [NV] = '{16'h1234, 16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                      16'h8000, 16'h0FFF, 16'h00FF, 16'h000F, 16'hFFFF};
  localparam logic [15:0] TB [NV] = '{16'h4321, 16'h4321, 16'h0000, 16'h0000, 16'hFFFF,
                                      16'h8000, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
  localparam logic        TC [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] TE [NV] = '{{1'b0, 16'h5555}, {1'b0, 16'h5556}, {1'b1, 16'h0000},
                                      {1'b0, 16'hFFFF}, {1'b1, 16'hFFFF}, {1'b1, 16'h0000},
                                      {1'b0, 16'h1000}, {1'b0, 16'h0100}, {1'b0, 16'h0010},
                                      {1'b1, 16'h0000}};

  task automatic test_directed();
    logic [19:0] exp;
    logic [19:0] obs;
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, TA[i], TB[i], TC[i]);
      exp = {1'b1, TE[i], ref_g(TA[i], TB[i]), ref_p(TA[i], TB[i])};
      #1;
      obs = {c_if.out_valid, c_if.co, c_if.s, c_if.g_out, c_if.p_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL directed_comb[%0d]: got %h want %h", i, obs, exp);
      end
      @(posedge clk);
      #1;
      obs = {r_if.out_valid, r_if.co, r_if.s, r_if.g_out, r_if.p_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL directed_reg[%0d]: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_stream();
    logic [19:0] m;     // expected registered outputs after the next edge
    logic [19:0] obs;
    logic [19:0] exp_c;
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    m = {1'b0, r_if.co, r_if.s, r_if.g_out, r_if.p_out};
    m = ref_all(1'b0, TA[NV-1], TB[NV-1], TC[NV-1]);
    for (int i = 0; i < 10000; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      reset = (i == 5000) || (i == 5001);
      drive(v, a, b, ci);
      #1;
      exp_c = ref_all(v, a, b, ci);
      obs   = {c_if.out_valid, c_if.co, c_if.s, c_if.g_out, c_if.p_out};
      checks++;
      if (obs !== exp_c) begin
        errors++;
        $display("FAIL stream_comb[%0d]: got %h want %h", i, obs, exp_c);
      end
      if (reset)  m = 20'h0;
      else if (v) m = exp_c;
      else        m[19] = 1'b0;
      @(posedge clk);
      #1;
      obs = {r_if.out_valid, r_if.co, r_if.s, r_if.g_out, r_if.p_out};
      checks++;
      if (obs !== m) begin
        errors++;
        $display("FAIL stream_reg[%0d]: got %h want %h", i, obs, m);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_chain();
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic [64:0] exp;
    logic [64:0] obs;
    for (int i = 0; i < 300; i++) begin
      if (i == 0) begin
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h0; ci = 1'b1;
      end else if (i == 1) begin
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; ci = 1'b1;
      end else begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; ci = 1'($urandom);
      end
      ch0.in_valid = 1'b1; ch1.in_valid = 1'b1; ch2.in_valid = 1'b1; ch3.in_valid = 1'b1;
      ch0.a = a[15:0];  ch0.b = b[15:0];  ch0.ci = ci;
      ch1.a = a[31:16]; ch1.b = b[31:16];
      ch2.a = a[47:32]; ch2.b = b[47:32];
      ch3.a = a[63:48]; ch3.b = b[63:48];
      #2;
      exp = {1'b0, a} + {1'b0, b} + {64'd0, ci};
      obs = {ch3.co, ch3.s, ch2.s, ch1.s, ch0.s};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL chain64[%0d]: got %h want %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    ch0.in_valid = 1'b0; ch1.in_valid = 1'b0; ch2.in_valid = 1'b0; ch3.in_valid = 1'b0;
    ch0.a = '0; ch0.b = '0; ch0.ci = 1'b0;
    ch1.a = '0; ch1.b = '0;
    ch2.a = '0; ch2.b = '0;
    ch3.a = '0; ch3.b = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_stream();
    test_chain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
